// File: rtl/spi_master_sequencer_if.sv
// Front-end side of the SPI master sequencer: transaction descriptor,
// start/abort handshake and status back to the register block.
interface spi_master_sequencer_if;
  logic        start_i;
  logic        ready_o;
  logic        abort_i;
  logic        en_quad_i;
  logic [5:0]  cmd_len_i;
  logic [5:0]  addr_len_i;
  logic [15:0] dummy_len_i;
  logic [15:0] tx_len_i;
  logic [15:0] rx_len_i;
  logic        busy_o;
  logic        eot_o;

  modport slave (
    input  start_i, abort_i, en_quad_i, cmd_len_i, addr_len_i,
           dummy_len_i, tx_len_i, rx_len_i,
    output ready_o, busy_o, eot_o
  );

  modport master (
    output start_i, abort_i, en_quad_i, cmd_len_i, addr_len_i,
           dummy_len_i, tx_len_i, rx_len_i,
    input  ready_o, busy_o, eot_o
  );
endinterface

// File: rtl/spi_master_sequencer.sv
// SPI transaction sequencer: walks CMD/ADDR/DUMMY/TX/RX phases of a latched
// descriptor, driving chip select and the TX/RX shift-block controls.
module spi_master_sequencer #(
  parameter int CS_HOLD_CYCLES = 2  // must be >= 1
) (
  input  logic        clk,
  input  logic        rstn,
  spi_master_sequencer_if.slave ctrl,
  output logic [1:0]  tx_sel_o,
  output logic        tx_en_o,
  output logic [15:0] tx_counter_o,
  output logic        tx_counter_upd_o,
  input  logic        tx_done_i,
  output logic        rx_en_o,
  output logic [15:0] rx_counter_o,
  output logic        rx_counter_upd_o,
  input  logic        rx_done_i,
  input  logic        clk_edge_i,
  output logic        spi_clk_en_o,
  output logic        en_quad_o,
  output logic        csn_o
);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, ADDR, DUMMY, TX, RX, CS_HOLD
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(CS_HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cmd_len_q, cmd_len_d, addr_len_q, addr_len_d;
  logic [15:0] dummy_len_q, dummy_len_d, tx_len_q, tx_len_d, rx_len_q, rx_len_d;
  logic        quad_q, quad_d;
  logic [15:0] dcnt_q, dcnt_d, hold_cnt_q, hold_cnt_d;

  logic [1:0]  tx_sel_q, tx_sel_d;
  logic        tx_en_q, tx_en_d, tx_upd_q, tx_upd_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic        rx_en_q, rx_en_d, rx_upd_q, rx_upd_d;
  logic        spi_clk_en_q, spi_clk_en_d, quad_o_q, quad_o_d;
  logic        csn_q, csn_d, busy_q, busy_d, eot_q, eot_d;

  // Phase index: 0 CMD, 1 ADDR, 2 DUMMY, 3 TX, 4 RX.
  logic [4:0]  nz;
  assign nz = {rx_len_q != '0, tx_len_q != '0, dummy_len_q != '0,
               addr_len_q != '0, cmd_len_q != '0};

  // First phase at or after index 'first' with a nonzero length.
  function automatic state_t pick_phase(input logic [2:0] first, input logic [4:0] mask);
    state_t r;
    r = CS_HOLD;
    if (mask[4] && first <= 3'd4) r = RX;
    if (mask[3] && first <= 3'd3) r = TX;
    if (mask[2] && first <= 3'd2) r = DUMMY;
    if (mask[1] && first <= 3'd1) r = ADDR;
    if (mask[0] && first == 3'd0) r = CMD;
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cmd_len_d   = cmd_len_q;
    addr_len_d  = addr_len_q;
    dummy_len_d = dummy_len_q;
    tx_len_d    = tx_len_q;
    rx_len_d    = rx_len_q;
    quad_d      = quad_q;
    dcnt_d      = '0;
    hold_cnt_d  = '0;

    case (state_q)
      IDLE: if (ctrl.start_i) begin
        state_d     = CS_SETUP;
        cmd_len_d   = ctrl.cmd_len_i;
        addr_len_d  = ctrl.addr_len_i;
        dummy_len_d = ctrl.dummy_len_i;
        tx_len_d    = ctrl.tx_len_i;
        rx_len_d    = ctrl.rx_len_i;
        quad_d      = ctrl.en_quad_i;
      end
      CS_SETUP: state_d = pick_phase(3'd0, nz);
      CMD:      if (tx_done_i) state_d = pick_phase(3'd1, nz);
      ADDR:     if (tx_done_i) state_d = pick_phase(3'd2, nz);
      DUMMY: begin
        dcnt_d = dcnt_q;
        if (clk_edge_i) begin
          dcnt_d = dcnt_q + 16'd1;
          if (dcnt_d == dummy_len_q) state_d = pick_phase(3'd3, nz);
        end
      end
      TX:       if (tx_done_i) state_d = pick_phase(3'd4, nz);
      RX:       if (rx_done_i) state_d = CS_HOLD;
      CS_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = IDLE;
        else                         hold_cnt_d = hold_cnt_q + 16'd1;
      end
      default:  state_d = IDLE;
    endcase

    // Abort beats any done strobe in the same cycle.
    if (ctrl.abort_i && !(state_q inside {IDLE, CS_HOLD})) state_d = CS_HOLD;
    if (state_d != DUMMY)   dcnt_d = '0;
    if (state_d != CS_HOLD) hold_cnt_d = '0;

    // Outputs are registered from the next state so they line up with it.
    tx_en_d      = state_d inside {CMD, ADDR, TX};
    rx_en_d      = state_d == RX;
    tx_upd_d     = tx_en_d && (state_d != state_q);
    rx_upd_d     = rx_en_d && (state_d != state_q);
    spi_clk_en_d = state_d == DUMMY;
    quad_o_d     = (state_d inside {ADDR, TX, RX}) ? quad_q : 1'b0;
    csn_d        = state_d == IDLE;
    busy_d       = state_d != IDLE;
    eot_d        = (state_d == CS_HOLD) && (hold_cnt_d == HOLD_LAST);
    rx_cnt_d     = rx_en_d ? rx_len_q : '0;
    tx_sel_d     = 2'd0;
    tx_cnt_d     = '0;
    case (state_d)
      CMD:  tx_cnt_d = {10'd0, cmd_len_q};
      ADDR: begin tx_sel_d = 2'd1; tx_cnt_d = {10'd0, addr_len_q}; end
      TX:   begin tx_sel_d = 2'd2; tx_cnt_d = tx_len_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cmd_len_q    <= '0;
      addr_len_q   <= '0;
      dummy_len_q  <= '0;
      tx_len_q     <= '0;
      rx_len_q     <= '0;
      quad_q       <= 1'b0;
      dcnt_q       <= '0;
      hold_cnt_q   <= '0;
      tx_sel_q     <= 2'd0;
      tx_en_q      <= 1'b0;
      tx_upd_q     <= 1'b0;
      tx_cnt_q     <= '0;
      rx_en_q      <= 1'b0;
      rx_upd_q     <= 1'b0;
      rx_cnt_q     <= '0;
      spi_clk_en_q <= 1'b0;
      quad_o_q     <= 1'b0;
      csn_q        <= 1'b1;
      busy_q       <= 1'b0;
      eot_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_len_q    <= cmd_len_d;
      addr_len_q   <= addr_len_d;
      dummy_len_q  <= dummy_len_d;
      tx_len_q     <= tx_len_d;
      rx_len_q     <= rx_len_d;
      quad_q       <= quad_d;
      dcnt_q       <= dcnt_d;
      hold_cnt_q   <= hold_cnt_d;
      tx_sel_q     <= tx_sel_d;
      tx_en_q      <= tx_en_d;
      tx_upd_q     <= tx_upd_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_en_q      <= rx_en_d;
      rx_upd_q     <= rx_upd_d;
      rx_cnt_q     <= rx_cnt_d;
      spi_clk_en_q <= spi_clk_en_d;
      quad_o_q     <= quad_o_d;
      csn_q        <= csn_d;
      busy_q       <= busy_d;
      eot_q        <= eot_d;
    end
  end

  assign ctrl.ready_o     = state_q == IDLE;
  assign ctrl.busy_o      = busy_q;
  assign ctrl.eot_o       = eot_q;
  assign tx_sel_o         = tx_sel_q;
  assign tx_en_o          = tx_en_q;
  assign tx_counter_o     = tx_cnt_q;
  assign tx_counter_upd_o = tx_upd_q;
  assign rx_en_o          = rx_en_q;
  assign rx_counter_o     = rx_cnt_q;
  assign rx_counter_upd_o = rx_upd_q;
  assign spi_clk_en_o     = spi_clk_en_q;
  assign en_quad_o        = quad_o_q;
  assign csn_o            = csn_q;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed bench for spi_master_sequencer: phase events are scoreboarded
// against expectations pushed when each descriptor is issued.
module tb_spi_master_sequencer;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  spi_master_sequencer_if ctrl();

  logic [1:0]  tx_sel_o;
  logic        tx_en_o, tx_counter_upd_o, rx_en_o, rx_counter_upd_o;
  logic        spi_clk_en_o, en_quad_o, csn_o;
  logic [15:0] tx_counter_o, rx_counter_o;
  logic        tx_done_i, rx_done_i, clk_edge_i;
  logic        tx_done_auto, rx_done_auto, tx_done_man, rx_done_man, man_mode;

  assign tx_done_i = tx_done_auto | tx_done_man;
  assign rx_done_i = rx_done_auto | rx_done_man;

  spi_master_sequencer #(.CS_HOLD_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .ctrl(ctrl),
    .tx_sel_o(tx_sel_o), .tx_en_o(tx_en_o), .tx_counter_o(tx_counter_o),
    .tx_counter_upd_o(tx_counter_upd_o), .tx_done_i(tx_done_i),
    .rx_en_o(rx_en_o), .rx_counter_o(rx_counter_o),
    .rx_counter_upd_o(rx_counter_upd_o), .rx_done_i(rx_done_i),
    .clk_edge_i(clk_edge_i), .spi_clk_en_o(spi_clk_en_o),
    .en_quad_o(en_quad_o), .csn_o(csn_o)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] sbq[$];
  int tcnt = 0, ttgt = 0, rcnt = 0, rtgt = 0;
  int edge_cnt = 0, eot_cnt = 0, csn_low_cnt = 0, txn_cnt = 0, any_en = 0;
  logic prev_spi_en = 1'b0, prev_csn = 1'b1;
  logic tx_done_seen = 1'b0, rx_done_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event word: kind(1 tx phase, 2 rx phase, 3 dummy, 4 eot), sel, quad, count.
  function automatic logic [31:0] ev(input logic [3:0] k, input logic [1:0] sel,
                                     input logic q, input logic [15:0] c);
    return {k, sel, q, 9'd0, c};
  endfunction

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = (sbq.size() != 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
    chk(tag, obs, exp);
  endtask

  function automatic int shift_cycles(input logic [15:0] bits, input logic q);
    int t;
    t = q ? int'(bits) / 4 : int'(bits);
    return (t == 0) ? 1 : t;
  endfunction

  always @(posedge clk) begin
    tx_done_seen = tx_done_i;
    rx_done_seen = rx_done_i;
  end

  // Monitor followed by a simple datapath/clock-generator responder.
  always @(negedge clk) begin
    if (rstn) begin
      if (tx_counter_upd_o) sb_pop("tx_phase", ev(4'd1, tx_sel_o, en_quad_o, tx_counter_o));
      if (rx_counter_upd_o) sb_pop("rx_phase", ev(4'd2, 2'd0, en_quad_o, rx_counter_o));
      if (spi_clk_en_o && !prev_spi_en) sb_pop("dummy_phase", ev(4'd3, 2'd0, 1'b0, 16'd0));
      if (ctrl.eot_o) begin
        eot_cnt++;
        sb_pop("eot", ev(4'd4, 2'd0, 1'b0, 16'd0));
      end
      if (tx_done_seen && tx_en_o) chk("tx_en_after_done", tx_counter_upd_o, 1);
      if (rx_done_seen) chk("rx_en_after_done", rx_en_o, 0);
      if (!csn_o) csn_low_cnt++;
      if (!csn_o && prev_csn) txn_cnt++;
      if (tx_en_o || rx_en_o || spi_clk_en_o) any_en = 1;
      prev_spi_en = spi_clk_en_o;
      prev_csn = csn_o;
    end
    if (tx_en_o) begin
      if (tx_counter_upd_o) begin tcnt = 1; ttgt = shift_cycles(tx_counter_o, en_quad_o); end
      else tcnt++;
    end else tcnt = 0;
    if (rx_en_o) begin
      if (rx_counter_upd_o) begin rcnt = 1; rtgt = shift_cycles(rx_counter_o, en_quad_o); end
      else rcnt++;
    end else rcnt = 0;
    tx_done_auto = !man_mode && tx_en_o && (tcnt == ttgt);
    rx_done_auto = !man_mode && rx_en_o && (rcnt == rtgt);
    clk_edge_i = spi_clk_en_o && !clk_edge_i;
    if (spi_clk_en_o && clk_edge_i) edge_cnt++;
  end

  task automatic start_txn(input int cmd, input int addr, input int dummy,
                           input int tx, input int rx, input logic q);
    csn_low_cnt = 0; edge_cnt = 0; eot_cnt = 0; txn_cnt = 0;
    ctrl.cmd_len_i = 6'(cmd);     ctrl.addr_len_i = 6'(addr);
    ctrl.dummy_len_i = 16'(dummy); ctrl.tx_len_i = 16'(tx);
    ctrl.rx_len_i = 16'(rx);      ctrl.en_quad_i = q;
    ctrl.start_i = 1'b1;
    if (cmd != 0)   sbq.push_back(ev(4'd1, 2'd0, 1'b0, 16'(cmd)));
    if (addr != 0)  sbq.push_back(ev(4'd1, 2'd1, q, 16'(addr)));
    if (dummy != 0) sbq.push_back(ev(4'd3, 2'd0, 1'b0, 16'd0));
    if (tx != 0)    sbq.push_back(ev(4'd1, 2'd2, q, 16'(tx)));
    if (rx != 0)    sbq.push_back(ev(4'd2, 2'd0, q, 16'(rx)));
    sbq.push_back(ev(4'd4, 2'd0, 1'b0, 16'd0));
    @(negedge clk);
    ctrl.start_i = 1'b0;
    chk("setup_csn", csn_o, 0);
    chk("setup_busy", ctrl.busy_o, 1);
    chk("setup_ready", ctrl.ready_o, 0);
    chk("setup_no_en", {tx_en_o, rx_en_o, spi_clk_en_o}, 0);
    // Scramble the descriptor: the latched copy must be what gets used.
    ctrl.cmd_len_i = 6'h3F; ctrl.addr_len_i = 6'h3F;
    ctrl.dummy_len_i = 16'hFFFF; ctrl.tx_len_i = 16'hFFFF; ctrl.rx_len_i = 16'hFFFF;
    ctrl.en_quad_i = ~q;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!ctrl.ready_o && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_idle_timeout"}, ctrl.ready_o, 1);
    chk({tag, "_sb_drain"}, sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ctrl.start_i = 0; ctrl.abort_i = 0; ctrl.en_quad_i = 0;
    ctrl.cmd_len_i = 0; ctrl.addr_len_i = 0; ctrl.dummy_len_i = 0;
    ctrl.tx_len_i = 0; ctrl.rx_len_i = 0;
    tx_done_man = 0; rx_done_man = 0; man_mode = 0;
    tx_done_auto = 0; rx_done_auto = 0; clk_edge_i = 0;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_csn", csn_o, 1);
    chk("rst_ready", ctrl.ready_o, 1);
    chk("rst_outs", {ctrl.busy_o, ctrl.eot_o, en_quad_o, tx_sel_o, spi_clk_en_o,
                     tx_en_o, tx_counter_upd_o, rx_en_o, rx_counter_upd_o}, 0);
    chk("rst_counters", {tx_counter_o, rx_counter_o}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Read: cmd 8, quad addr 24, 4 dummy edges, quad rx 32.
    start_txn(8, 24, 4, 0, 32, 1'b1);
    @(negedge clk);
    chk("read_first_phase_lat", {tx_en_o, tx_counter_o}, {1'b1, 16'd8});
    wait_idle("read", 200);
    chk("read_csn_low", csn_low_cnt, 32);
    chk("read_dummy_edges", edge_cnt, 4);
    chk("read_eot", eot_cnt, 1);

    // Write with skipped phases; a start pulse mid-transfer must be dropped.
    start_txn(8, 0, 0, 64, 0, 1'b0);
    repeat (5) @(negedge clk);
    ctrl.start_i = 1'b1;
    @(negedge clk);
    ctrl.start_i = 1'b0;
    wait_idle("write", 200);
    chk("write_csn_low", csn_low_cnt, 75);
    repeat (3) @(negedge clk);
    chk("write_start_not_queued", {csn_o, 32'(txn_cnt)}, {1'b1, 32'd1});

    // All lengths zero.
    any_en = 0;
    start_txn(0, 0, 0, 0, 0, 1'b0);
    wait_idle("zero", 20);
    chk("zero_csn_low", csn_low_cnt, 3);
    chk("zero_eot", eot_cnt, 1);
    chk("zero_no_enable", any_en, 0);

    // Abort mid-RX; abort stays high through CS_HOLD and IDLE where it is ignored.
    start_txn(0, 0, 0, 0, 256, 1'b0);
    n = 0;
    while (rcnt < 40 && n < 100) begin @(negedge clk); n++; end
    chk("abort_reached_bit40", rx_en_o, 1);
    ctrl.abort_i = 1'b1;
    @(negedge clk);
    chk("abort_rx_en_low", rx_en_o, 0);
    chk("abort_csn_hold", {csn_o, ctrl.eot_o}, 0);
    @(negedge clk);
    chk("abort_eot_pulse", ctrl.eot_o, 1);
    wait_idle("abort_rx", 10);
    repeat (2) @(negedge clk);
    ctrl.abort_i = 1'b0;
    chk("abort_idle_ignored", {csn_o, ctrl.ready_o, 32'(eot_cnt)}, {1'b1, 1'b1, 32'd1});

    // Abort together with tx_done: RX must not start.
    man_mode = 1'b1;
    start_txn(0, 0, 0, 8, 8, 1'b0);
    repeat (3) @(negedge clk);
    chk("abdone_in_tx", tx_en_o, 1);
    void'(sbq.pop_front());
    tx_done_man = 1'b1; ctrl.abort_i = 1'b1;
    @(negedge clk);
    tx_done_man = 1'b0; ctrl.abort_i = 1'b0;
    chk("abdone_tx_en_low", {tx_en_o, rx_en_o}, 0);
    wait_idle("abdone_tx", 10);
    chk("abdone_tx_eot", eot_cnt, 1);

    // Abort together with rx_done.
    start_txn(0, 0, 0, 0, 8, 1'b0);
    repeat (3) @(negedge clk);
    chk("abdone_in_rx", rx_en_o, 1);
    rx_done_man = 1'b1; ctrl.abort_i = 1'b1;
    @(negedge clk);
    rx_done_man = 1'b0; ctrl.abort_i = 1'b0;
    chk("abdone_rx_en_low", rx_en_o, 0);
    wait_idle("abdone_rx", 10);
    chk("abdone_rx_eot", {csn_o, 32'(eot_cnt)}, {1'b1, 32'd1});
    man_mode = 1'b0;

    // start_i held high: one transaction per IDLE visit.
    csn_low_cnt = 0; eot_cnt = 0; txn_cnt = 0;
    ctrl.cmd_len_i = 6'd8; ctrl.addr_len_i = 0; ctrl.dummy_len_i = 0;
    ctrl.tx_len_i = 0; ctrl.rx_len_i = 0; ctrl.en_quad_i = 0;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(ev(4'd1, 2'd0, 1'b0, 16'd8));
      sbq.push_back(ev(4'd4, 2'd0, 1'b0, 16'd0));
    end
    ctrl.start_i = 1'b1;
    n = 0;
    while (txn_cnt < 2 && n < 60) begin @(negedge clk); n++; end
    ctrl.start_i = 1'b0;
    chk("held_second_txn", txn_cnt, 2);
    wait_idle("held", 40);
    repeat (3) @(negedge clk);
    chk("held_txn_count", {32'(txn_cnt), 32'(eot_cnt)}, {32'd2, 32'd2});
    chk("held_csn_low", csn_low_cnt, 22);

    // Reset during DUMMY.
    start_txn(8, 0, 16, 0, 8, 1'b0);
    n = 0;
    while (!spi_clk_en_o && n < 30) begin @(negedge clk); n++; end
    chk("rstmid_in_dummy", spi_clk_en_o, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rstmid_csn_clk", {csn_o, spi_clk_en_o}, {1'b1, 1'b0});
    chk("rstmid_ready_busy", {ctrl.ready_o, ctrl.busy_o}, {1'b1, 1'b0});
    chk("rstmid_outs", {ctrl.eot_o, en_quad_o, tx_sel_o, tx_en_o, tx_counter_upd_o,
                        rx_en_o, rx_counter_upd_o, tx_counter_o, rx_counter_o}, 0);
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
    txn_cnt = 0;
    repeat (5) @(negedge clk);
    chk("rstmid_descriptor_dropped", {csn_o, ctrl.ready_o, 32'(txn_cnt)}, {1'b1, 1'b1, 32'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
